// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the dmem_dma engine.
//   - AW_DEF / DW_DEF : default address and data widths
//   - dma_state_t     : engine FSM state encoding
package dma_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

endpackage : dma_pkg

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: current source/destination address for the byte being moved.
// Ports:
//   i_src_base / i_dst_base : first source / destination address
//   i_count                 : bytes already written
//   i_len                   : transfer length
//   i_desc                  : 1 = walk from offset len-1 down to 0
//   o_src_addr / o_dst_addr : base + offset, wrapping modulo 2^AW
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] i_src_base,
    input  logic [AW-1:0] i_dst_base,
    input  logic [AW-1:0] i_count,
    input  logic [AW-1:0] i_len,
    input  logic          i_desc,
    output logic [AW-1:0] o_src_addr,
    output logic [AW-1:0] o_dst_addr
);

    localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] w_offset;

    // Offset of the current byte; descending walks start at the last byte.
    always_comb begin
        w_offset = i_count;
        if (i_desc) begin
            w_offset = i_len - i_count - ONE_AW;
        end else begin
            w_offset = i_count;
        end
    end

    assign o_src_addr = i_src_base + w_offset;
    assign o_dst_addr = i_dst_base + w_offset;

endmodule : dma_addr_gen

// File: rtl/dmem_dma.sv
// dmem_dma: copy/fill DMA engine driving a single-port data memory whose
// read data is combinational from the address.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   start, fill, src_addr, dst_addr,
//   len, fill_val                  : transfer request, sampled in IDLE only
//   busy, done                     : status (done is a one-cycle pulse)
//   mem_write, mem_addr, mem_wdata : memory command (all registered)
//   mem_rdata                      : memory read data for mem_addr
// A copy costs READ+WRITE per byte; a fill costs one WRITE per byte.
// Overlapping copies with dst ahead of src run descending so that source
// bytes are read before they are overwritten.
module dmem_dma
    import dma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fill,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_AW  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};

    dma_state_t    r_state, w_state_nx;
    logic [AW-1:0] r_src, r_dst, r_len, r_count;
    logic          r_fill, r_desc;
    logic [DW-1:0] r_fill_val, r_buf;
    logic          r_busy, r_done, r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic [AW-1:0] w_src_nx, w_dst_nx, w_len_nx, w_count_nx, w_count_inc;
    logic          w_fill_nx, w_desc_nx, w_desc_req;
    logic [DW-1:0] w_fval_nx, w_buf_nx;
    logic [AW-1:0] w_diff, w_src_cur, w_dst_cur;
    logic          w_busy_nx, w_done_nx, w_we_nx;
    logic [AW-1:0] w_addr_nx;
    logic [DW-1:0] w_wdata_nx;

    // Ring distance from source to destination decides the walk direction.
    assign w_diff      = dst_addr - src_addr;
    assign w_desc_req  = ~fill & (dst_addr != src_addr) & (w_diff < len);
    assign w_count_inc = r_count + ONE_AW;

    // Next-state, operand latch, count and read buffer.
    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_dst_nx   = r_dst;
        w_len_nx   = r_len;
        w_fill_nx  = r_fill;
        w_fval_nx  = r_fill_val;
        w_desc_nx  = r_desc;
        w_count_nx = r_count;
        w_buf_nx   = r_buf;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_src_nx   = src_addr;
                    w_dst_nx   = dst_addr;
                    w_len_nx   = len;
                    w_fill_nx  = fill;
                    w_fval_nx  = fill_val;
                    w_desc_nx  = w_desc_req;
                    w_count_nx = ZERO_AW;
                    if (len == ZERO_AW) begin
                        w_state_nx = ST_DONE;
                    end else if (fill) begin
                        w_state_nx = ST_WRITE;
                    end else begin
                        w_state_nx = ST_READ;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_READ: begin
                w_buf_nx   = mem_rdata;
                w_state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                w_count_nx = w_count_inc;
                if (w_count_inc == r_len) begin
                    w_state_nx = ST_DONE;
                end else if (r_fill) begin
                    w_state_nx = ST_WRITE;
                end else begin
                    w_state_nx = ST_READ;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Addresses are formed from next-cycle operands so the memory command
    // can be registered and still line up with the state it belongs to.
    dma_addr_gen #(.AW(AW)) u_addr_gen (
        .i_src_base (w_src_nx),
        .i_dst_base (w_dst_nx),
        .i_count    (w_count_nx),
        .i_len      (w_len_nx),
        .i_desc     (w_desc_nx),
        .o_src_addr (w_src_cur),
        .o_dst_addr (w_dst_cur)
    );

    // Memory command and status for the state being entered.
    always_comb begin
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_we_nx    = 1'b0;
        w_addr_nx  = ZERO_AW;
        w_wdata_nx = ZERO_DW;
        case (w_state_nx)
            ST_READ: begin
                w_busy_nx = 1'b1;
                w_addr_nx = w_src_cur;
            end
            ST_WRITE: begin
                w_busy_nx  = 1'b1;
                w_we_nx    = 1'b1;
                w_addr_nx  = w_dst_cur;
                w_wdata_nx = w_fill_nx ? w_fval_nx : w_buf_nx;
            end
            ST_DONE: begin
                w_done_nx = 1'b1;
            end
            ST_IDLE: begin
                w_busy_nx = 1'b0;
            end
            default: begin
                w_busy_nx = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Operand, count, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src       <= ZERO_AW;
            r_dst       <= ZERO_AW;
            r_len       <= ZERO_AW;
            r_count     <= ZERO_AW;
            r_fill      <= 1'b0;
            r_desc      <= 1'b0;
            r_fill_val  <= ZERO_DW;
            r_buf       <= ZERO_DW;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= ZERO_AW;
            r_mem_wdata <= ZERO_DW;
        end else begin
            r_src       <= w_src_nx;
            r_dst       <= w_dst_nx;
            r_len       <= w_len_nx;
            r_count     <= w_count_nx;
            r_fill      <= w_fill_nx;
            r_desc      <= w_desc_nx;
            r_fill_val  <= w_fval_nx;
            r_buf       <= w_buf_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_mem_write <= w_we_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_wdata <= w_wdata_nx;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule : dmem_dma

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: scoreboard bench for dmem_dma. The stimulus side computes the
// expected bus cycles of each transfer (memmove semantics on a snapshot of
// the reference memory) and queues them; a monitor pops and compares every
// busy cycle and done pulse.
module tb_dmem_dma;

    typedef struct {
        int         kind;   // 0 read, 1 write, 2 done
        logic [7:0] addr;
        logic [7:0] data;
        int         busy_cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, start, fill;
    logic [7:0] src_addr, dst_addr, len, fill_val;
    logic       busy, done, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       tb_we;
    logic [7:0] tb_wa, tb_wd;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  busy_run = 0;

    always #5 clk = ~clk;

    dmem_dma #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fill      (fill),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory: bench preload port has priority over the DUT write port.
    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic setb(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_image(input string name);
        int nbad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s mem_image bytes_wrong=%0d first_addr=%0d got=%h want=%h",
                     name, nbad, first, mem[first], ref_mem[first]);
        end
    endtask

    // Queue the expected bus cycles of one transfer, run it, check latency
    // and the resulting memory image. n_apply limits how many writes reach
    // the reference memory (used when the transfer is aborted).
    task automatic run_xfer(input string name, input logic f, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] l, input logic [7:0] fv,
                            input bit poke, input bit abort);
        logic [7:0] snap [256];
        logic [7:0] sa, da, wv;
        int  diff, off, busy_exp, lat, wc, n_apply;
        bit  desc, got, aborted;
        ev_t e;
        n_apply = abort ? 2 : 256;
        for (int i = 0; i < 256; i++) snap[i] = ref_mem[i];
        diff = (int'(d) - int'(s) + 256) % 256;
        desc = !f && (d != s) && (diff < int'(l));
        for (int k = 0; k < int'(l); k++) begin
            off = desc ? (int'(l) - 1 - k) : k;
            sa  = s + 8'(off);
            da  = d + 8'(off);
            wv  = f ? fv : snap[sa];
            if (!f) begin
                e.kind = 0; e.addr = sa; e.data = 8'h00; e.busy_cyc = 0;
                exp_q.push_back(e);
            end
            e.kind = 1; e.addr = da; e.data = wv; e.busy_cyc = 0;
            exp_q.push_back(e);
            if (k < n_apply) ref_mem[da] = wv;
        end
        busy_exp = f ? int'(l) : 2 * int'(l);
        e.kind = 2; e.addr = 8'h00; e.data = 8'h00; e.busy_cyc = busy_exp;
        exp_q.push_back(e);

        @(posedge clk); #1;
        start = 1'b1; fill = f; src_addr = s; dst_addr = d; len = l; fill_val = fv;
        @(posedge clk); #1;
        start = 1'b0;
        fill = 1'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
        len = 8'($urandom); fill_val = 8'($urandom);

        lat = 0; got = 1'b0; wc = 0; aborted = 1'b0;
        for (int c = 0; c < 600 && !got && !aborted; c++) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 3) begin
                start = 1'b1; fill = 1'($urandom); src_addr = 8'($urandom);
                dst_addr = 8'($urandom); len = 8'($urandom_range(1, 20)); fill_val = 8'($urandom);
            end
            if (poke && lat == 4) start = 1'b0;
            if (mem_write) wc++;
            if (done) got = 1'b1;
            if (abort && wc == 2) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                total++;
                if ({busy, done, mem_write, mem_addr, mem_wdata} !== 19'd0) begin
                    bad++;
                    $display("FAIL %s abort_outputs got busy=%b done=%b we=%b addr=%h wdata=%h want all zero",
                             name, busy, done, mem_write, mem_addr, mem_wdata);
                end
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
            end
        end
        if (!abort) begin
            total++;
            if (!got || lat != busy_exp + 1) begin
                bad++;
                $display("FAIL %s done_latency got=%0d (seen=%0d) want=%0d", name, lat, got, busy_exp + 1);
            end
        end else begin
            total++;
            if (!aborted) begin
                bad++;
                $display("FAIL %s abort_point got writes=%0d want=2", name, wc);
            end
        end
        @(negedge clk);
        check_image(name);
    endtask

    initial begin
        start = 1'b0; fill = 1'b0; src_addr = 8'h00; dst_addr = 8'h00;
        len = 8'h00; fill_val = 8'h00; tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, mem_write, mem_addr, mem_wdata} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b addr=%h wdata=%h want all zero",
                     busy, done, mem_write, mem_addr, mem_wdata);
        end

        // Monitor: every busy cycle and every done pulse consumes one entry.
        fork
            forever begin
                ev_t m;
                @(negedge clk);
                if (!rst_n) begin
                    busy_run = 0;
                end else begin
                    if (busy) begin
                        busy_run++;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL bus_cycle got we=%b addr=%h want no activity", mem_write, mem_addr);
                        end else begin
                            m = exp_q.pop_front();
                            if (mem_write) begin
                                if (m.kind != 1 || mem_addr !== m.addr || mem_wdata !== m.data) begin
                                    bad++;
                                    $display("FAIL write got addr=%h data=%h want kind=%0d addr=%h data=%h",
                                             mem_addr, mem_wdata, m.kind, m.addr, m.data);
                                end
                            end else begin
                                if (m.kind != 0 || mem_addr !== m.addr) begin
                                    bad++;
                                    $display("FAIL read got addr=%h want kind=%0d addr=%h",
                                             mem_addr, m.kind, m.addr);
                                end
                            end
                        end
                    end else begin
                        total++;
                        if (mem_write !== 1'b0 || mem_addr !== 8'h00) begin
                            bad++;
                            $display("FAIL idle_bus got we=%b addr=%h want we=0 addr=00", mem_write, mem_addr);
                        end
                    end
                    if (done) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL done_pulse got unexpected done want none");
                        end else begin
                            m = exp_q.pop_front();
                            if (m.kind != 2 || busy_run != m.busy_cyc || busy) begin
                                bad++;
                                $display("FAIL done_pulse got kind=%0d busy_cycles=%0d busy=%b want kind=2 busy_cycles=%0d busy=0",
                                         m.kind, busy_run, busy, m.busy_cyc);
                            end
                        end
                        busy_run = 0;
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) setb(8'(i), 8'($urandom));

        // Plain copy.
        setb(8'd0, 8'd11); setb(8'd1, 8'd22); setb(8'd2, 8'd33); setb(8'd3, 8'd44);
        run_xfer("copy", 1'b0, 8'h00, 8'h04, 8'd4, 8'h00, 1'b0, 1'b0);
        chk8("copy_m4", mem[4], 8'd11);
        chk8("copy_m7", mem[7], 8'd44);

        // Overlapping copy, destination ahead of source.
        setb(8'd0, 8'd1); setb(8'd1, 8'd2); setb(8'd2, 8'd3); setb(8'd3, 8'd4);
        run_xfer("overlap", 1'b0, 8'h00, 8'h01, 8'd4, 8'h00, 1'b0, 1'b0);
        chk8("overlap_m0", mem[0], 8'd1);
        chk8("overlap_m1", mem[1], 8'd1);
        chk8("overlap_m4", mem[4], 8'd4);

        // Fill.
        run_xfer("fill", 1'b1, 8'h00, 8'h02, 8'd3, 8'hA5, 1'b0, 1'b0);
        chk8("fill_m4", mem[4], 8'hA5);

        // Zero length, copy and fill.
        run_xfer("len0", 1'b0, 8'h30, 8'h40, 8'd0, 8'h00, 1'b0, 1'b0);
        run_xfer("len0_fill", 1'b1, 8'h30, 8'h40, 8'd0, 8'h77, 1'b0, 1'b0);

        // Address wrap.
        setb(8'hFE, 8'hC1); setb(8'hFF, 8'hC2); setb(8'h00, 8'hC3);
        run_xfer("wrap", 1'b0, 8'hFE, 8'h10, 8'd3, 8'h00, 1'b0, 1'b0);
        chk8("wrap_m12", mem[8'h12], 8'hC3);

        // In-place copy and ignored mid-transfer start.
        run_xfer("same_addr", 1'b0, 8'h50, 8'h50, 8'd5, 8'h00, 1'b0, 1'b0);
        run_xfer("poke", 1'b0, 8'h60, 8'h70, 8'd6, 8'h00, 1'b1, 1'b0);

        // Abort after the second write, then a fresh transfer.
        run_xfer("abort", 1'b0, 8'h20, 8'h80, 8'd4, 8'h00, 1'b0, 1'b1);
        run_xfer("after_abort", 1'b0, 8'h20, 8'h90, 8'd4, 8'h00, 1'b0, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            logic       rf;
            logic [7:0] rs, rd, rl;
            rf = ($urandom_range(0, 2) == 0);
            rs = 8'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? rs + 8'($urandom_range(0, 8)) : 8'($urandom);
            rl = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            run_xfer("random", rf, rs, rd, rl, 8'($urandom), (rl >= 8'd4) && ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_dma

// File: doc/dmem_dma.md
DMEM_DMA -- requirements
Module: dmem_dma

Interface
REQ-001 Parameter AW, default 8: address width; matches the data memory address port.
REQ-002 Parameter DW, default 8: data width; matches the data memory data port.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 fill  input  1  0 = copy src->dst; 1 = write fill_val to dst range; sampled with start.
REQ-007 src_addr  input  AW  first source address; sampled with start.
REQ-008 dst_addr  input  AW  first destination address; sampled with start.
REQ-009 len  input  AW  byte count, 0..255; sampled with start.
REQ-010 fill_val  input  DW  fill constant; sampled with start.
REQ-011 busy  output  1  high while in READ or WRITE.
REQ-012 done  output  1  one-cycle pulse at transfer end.
REQ-013 mem_write  output  1  memory write enable.
REQ-014 mem_addr  output  AW  memory address, shared by read and write.
REQ-015 mem_wdata  output  DW  memory write data.
REQ-016 mem_rdata  input  DW  memory read data; combinational from mem_addr, same cycle.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-018 IDLE, start=1, len!=0 SHALL latch all operands, clear count, and go to READ, or to WRITE when fill=1.
REQ-019 IDLE, start=1, len=0 SHALL go directly to DONE with no memory write.
REQ-020 READ SHALL drive mem_addr=current source address and mem_write=0, capture mem_rdata into a DW-bit buffer at the edge, then go to WRITE.
REQ-021 WRITE SHALL drive mem_addr=current destination address, mem_write=1 and mem_wdata=buffer (copy) or fill_val (fill).
REQ-022 At the end of WRITE, count SHALL increment; if count reaches len, go to DONE, else go to READ (copy) or stay in WRITE (fill).
REQ-023 Copy SHALL cost 2 cycles per byte; fill SHALL cost 1 cycle per byte; DONE follows the last write by exactly one cycle.
REQ-024 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-025 Addresses SHALL wrap modulo 2^AW.
REQ-026 Direction rule, copy only: if dst!=src and ((dst-src) mod 2^AW) < len, the transfer SHALL run descending from offset len-1 to 0; otherwise it runs ascending from offset 0.
REQ-027 dst==src in copy mode SHALL still perform all reads and writes, leaving the data unchanged.
REQ-028 start outside IDLE SHALL be ignored; operands SHALL not change mid-transfer.
REQ-029 In IDLE and DONE, mem_write SHALL be 0 and mem_addr SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, done=0, mem_write=0, mem_addr=0, mem_wdata=0, buffer=0 and count=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no further writes; bytes already written stay written.

Structure
REQ-032 Package dma_pkg SHALL hold the state enum typedef and the AW/DW defaults.
REQ-033 One sub-module, dma_addr_gen, SHALL compute current source and destination addresses from base, count, len and direction.

Verification
REQ-034 Copy: mem[0..3]={11,22,33,44}, start src=0 dst=4 len=4 -> mem[4..7]={11,22,33,44}; busy high for 8 cycles; done pulse on cycle 9.
REQ-035 Overlap: mem[0..3]={1,2,3,4}, src=0 dst=1 len=4 -> descending order; mem[1..4]={1,2,3,4}, mem[0]=1.
REQ-036 Fill: fill=1 fill_val=8'hA5 dst=2 len=3 -> mem[2..4]=A5; exactly 3 write cycles.
REQ-037 len=0: start -> done pulse on the next cycle; mem_write never asserted.
REQ-038 Wrap: src=8'hFE dst=8'h10 len=3 -> bytes from FE, FF, 00 land at 10, 11, 12.
REQ-039 Abort: rst_n low after the 2nd write of a len=4 copy -> outputs 0 asynchronously; only the first 2 destination bytes change; a new start after release works.
